dag2_result_fifo: RTL and testbench

//  Downstream stage of the dag2 datapath: captures each registered {out0,out1} result into a small FIFO.

---
 rtl/dag2_result_fifo_pkg.sv | 15 +
 rtl/dag2_result_fifo_if.sv | 28 ++
 rtl/dag2_result_fifo_mem.sv | 22 ++
 rtl/dag2_result_fifo.sv | 102 ++++++++++
 tb/tb_dag2_result_fifo.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dag2_result_fifo_pkg.sv
// Shared types and default sizes for the dag2 result FIFO.
// State encodings: EMPTY = 0, PARTIAL = 1, FULL = 2; code 3 is illegal.
package dag2_result_fifo_pkg;

    localparam int DAG2_BITS  = 2;
    localparam int DAG2_DEPTH = 4;
    localparam int DAG2_ADDR  = 2;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/dag2_result_fifo_if.sv
// Producer/consumer handshake bundle of the dag2 result FIFO; the master drives data in and ready.
// The FIFO connects through the slave modport, which drives valid, head data and status flags.
interface dag2_result_fifo_if #(
    parameter int BITS = 2,
    parameter int ADDR = 2
);
    logic            in_valid;
    logic [BITS-1:0] in_data0;
    logic            in_data1;
    logic            out_ready;
    logic            out_valid;
    logic [BITS-1:0] out_data0;
    logic            out_data1;
    logic            full;
    logic            empty;
    logic [ADDR:0]   count;
    logic            overflow;

    modport master (
        output in_valid, in_data0, in_data1, out_ready,
        input  out_valid, out_data0, out_data1, full, empty, count, overflow
    );

    modport slave (
        input  in_valid, in_data0, in_data1, out_ready,
        output out_valid, out_data0, out_data1, full, empty, count, overflow
    );
endinterface

// File: rtl/dag2_result_fifo_mem.sv
// DEPTH x W register file for the result FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset; the control logic gates what is visible.
module dag2_fifo_mem #(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    parameter int ADDR  = 2
) (
    input  logic            clock,
    input  logic            we,
    input  logic [ADDR-1:0] waddr,
    input  logic [W-1:0]    wdata,
    input  logic [ADDR-1:0] raddr,
    output logic [W-1:0]    rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dag2_result_fifo.sv
// Result FIFO behind dag2: entries pushed at edge N are visible at N+1 (no bypass); drops on full set sticky overflow.
// Backpressure via out_ready; a full FIFO still accepts when popping the same cycle. DAG2_FIFO_STATS_EN adds push/drop counters.
module dag2_result_fifo
    import dag2_result_fifo_pkg::*;
#(
    parameter int BITS  = DAG2_BITS,
    parameter int DEPTH = DAG2_DEPTH,
    parameter int ADDR  = DAG2_ADDR
) (
    input  logic                clock,
    input  logic                reset,
    dag2_result_fifo_if.slave   bus
`ifdef DAG2_FIFO_STATS_EN
    ,
    output logic [7:0]          push_count,
    output logic [7:0]          drop_count
`endif
);
    localparam logic [ADDR:0] CNT_LAST = (ADDR+1)'(DEPTH-1);
    localparam logic [ADDR:0] CNT_ONE  = (ADDR+1)'(1);

    logic [ADDR-1:0] rd_ptr;
    logic [ADDR-1:0] wr_ptr;
    logic [ADDR:0]   cnt;
    logic            ovf;
    fifo_state_t     state;
    logic [BITS:0]   rdata;
    logic            pop;
    logic            push;
    logic            drop;

    assign bus.out_valid = (state == ST_PARTIAL) || (state == ST_FULL);
    assign bus.full      = (state == ST_FULL);
    assign bus.empty     = !bus.out_valid;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.in_valid & (!bus.full | pop);
    assign drop = bus.in_valid & bus.full & !pop;

    dag2_fifo_mem #(.W(BITS+1), .DEPTH(DEPTH), .ADDR(ADDR)) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({bus.in_data0, bus.in_data1}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Storage is never cleared, so stale contents are masked while empty.
    assign bus.out_data0 = bus.out_valid ? rdata[BITS:1] : '0;
    assign bus.out_data1 = bus.out_valid ? rdata[0] : 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            state  <= ST_EMPTY;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            if (drop) ovf <= 1'b1;

            case (state)
                ST_EMPTY: begin
                    if (push) state <= ST_PARTIAL;
                end
                ST_PARTIAL: begin
                    if (push && !pop && cnt == CNT_LAST)     state <= ST_FULL;
                    else if (pop && !push && cnt == CNT_ONE) state <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop && !push) state <= ST_PARTIAL;
                end
                default: begin
                    // Illegal code: restart coherently from empty.
                    state  <= ST_EMPTY;
                    cnt    <= '0;
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end
            endcase
        end
    end

`ifdef DAG2_FIFO_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            push_count <= 8'd0;
            drop_count <= 8'd0;
        end else begin
            if (push) push_count <= push_count + 8'd1;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dag2_result_fifo.sv
// Bench for dag2_result_fifo: fixed vector table, reset/stream corner cases and a random run against a queue model.
module tb_dag2_result_fifo;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;
`ifdef DAG2_FIFO_STATS_EN
    logic [7:0] push_count;
    logic [7:0] drop_count;
`endif

    dag2_result_fifo_if #(.BITS(2), .ADDR(2)) bus ();

    dag2_result_fifo #(.BITS(2), .DEPTH(DEPTH), .ADDR(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DAG2_FIFO_STATS_EN
        ,
        .push_count (push_count),
        .drop_count (drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {data0,data1} plus sticky/stat counters.
    logic [2:0] q[$];
    bit         m_ovf = 0;
    int         m_push = 0;
    int         m_drop = 0;

    typedef struct {
        bit         iv;
        logic [1:0] d0;
        bit         d1;
        bit         rdy;
        bit         e_vld;
        logic [1:0] e_d0;
        bit         e_d1;
        bit         e_full;
        logic [2:0] e_cnt;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {bus.out_valid, bus.out_data0, bus.out_data1, bus.full, bus.empty, bus.count, bus.overflow};
    endfunction

    function automatic logic [9:0] model_vec();
        logic [2:0] head;
        head = (q.size() > 0) ? q[0] : 3'b000;
        return {q.size() > 0, head, q.size() == DEPTH, q.size() == 0, 3'(q.size()), m_ovf};
    endfunction

    // Apply inputs at the falling edge, advance one rising edge, return at the next falling edge.
    task automatic cycle(input bit iv, input logic [1:0] d0, input bit d1, input bit rdy);
        bit mpop, mpush;
        bus.in_valid  = iv;
        bus.in_data0  = d0;
        bus.in_data1  = d1;
        bus.out_ready = rdy;
        mpop  = (q.size() > 0) && rdy;
        mpush = iv && ((q.size() < DEPTH) || mpop);
        @(posedge clock);
        if (mpop) void'(q.pop_front());
        if (mpush) begin
            q.push_back({d0, d1});
            m_push = (m_push + 1) % 256;
        end else if (iv) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
        end
        @(negedge clock);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_push = 0;
        m_drop = 0;
    endtask

    initial begin
        tbl[0]  = '{1, 2'd2, 1, 0,  1, 2'd2, 1, 0, 3'd1, 0};
        tbl[1]  = '{0, 2'd0, 0, 1,  0, 2'd0, 0, 0, 3'd0, 0};
        tbl[2]  = '{1, 2'd0, 0, 0,  1, 2'd0, 0, 0, 3'd1, 0};
        tbl[3]  = '{1, 2'd1, 0, 0,  1, 2'd0, 0, 0, 3'd2, 0};
        tbl[4]  = '{1, 2'd2, 0, 0,  1, 2'd0, 0, 0, 3'd3, 0};
        tbl[5]  = '{1, 2'd3, 0, 0,  1, 2'd0, 0, 1, 3'd4, 0};
        tbl[6]  = '{1, 2'd1, 1, 0,  1, 2'd0, 0, 1, 3'd4, 1};
        tbl[7]  = '{1, 2'd3, 1, 1,  1, 2'd1, 0, 1, 3'd4, 1};
        tbl[8]  = '{0, 2'd0, 0, 1,  1, 2'd2, 0, 0, 3'd3, 1};
        tbl[9]  = '{0, 2'd0, 0, 1,  1, 2'd3, 0, 0, 3'd2, 1};
        tbl[10] = '{0, 2'd0, 0, 1,  1, 2'd3, 1, 0, 3'd1, 1};
        tbl[11] = '{0, 2'd0, 0, 1,  0, 2'd0, 0, 0, 3'd0, 1};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data0  = 2'd0;
        bus.in_data1  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_state", dut_vec(), 10'b0_00_0_0_1_000_0);
`ifdef DAG2_FIFO_STATS_EN
        chk("reset_stats", {2'b00, push_count}, 10'd0);
        chk("reset_drops", {2'b00, drop_count}, 10'd0);
`endif
        reset = 1'b0;
        @(negedge clock);

        // No bypass: with an input offered to an empty FIFO, nothing is visible before the edge.
        bus.in_valid = 1'b1;
        bus.in_data0 = 2'd2;
        bus.in_data1 = 1'b1;
        #1;
        chk("no_bypass", {9'd0, bus.out_valid}, 10'd0);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].iv, tbl[i].d0, tbl[i].d1, tbl[i].rdy);
            chk($sformatf("vec%0d", i), dut_vec(),
                {tbl[i].e_vld, tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_full, !tbl[i].e_vld, tbl[i].e_cnt, tbl[i].e_ovf});
            chk($sformatf("vec%0d_model", i), dut_vec(), model_vec());
`ifdef DAG2_FIFO_STATS_EN
            if (i == 6) chk("drop_count_one", {2'b00, drop_count}, 10'd1);
`endif
        end

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) cycle(1, 2'(i + 1), 1, 0);
        chk("pre_reset", dut_vec(), model_vec());
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset", dut_vec(), 10'b0_00_0_0_1_000_0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        cycle(1, 2'd1, 0, 0);
        chk("post_reset", dut_vec(), model_vec());
        cycle(0, 2'd0, 0, 1);
        chk("post_reset_pop", dut_vec(), 10'b0_00_0_0_1_000_0);

        // Streaming at full throughput: one-cycle latency, count never passes 1.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 2'(i), i[0], 1);
            chk($sformatf("stream%0d", i), {3'b000, bus.out_valid, bus.out_data0, bus.out_data1, bus.count},
                {3'b000, 1'b1, 2'(i), i[0], 3'd1});
        end
        cycle(0, 2'd0, 0, 1);
        chk("stream_drain", dut_vec(), model_vec());

        for (int i = 0; i < 400; i++) begin
            bit rdy;
            rdy = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rdy);
            chk("random", dut_vec(), model_vec());
`ifdef DAG2_FIFO_STATS_EN
            chk("random_push_count", {2'b00, push_count}, 10'(m_push));
            chk("random_drop_count", {2'b00, drop_count}, 10'(m_drop));
`endif
        end

`ifdef DAG2_FIFO_STATS_EN
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) cycle(1, 2'(i), 0, 1);
        chk("push_count_wrap", {2'b00, push_count}, 10'd44);
        for (int i = 0; i < 264; i++) cycle(1, 2'd3, 1, 0);
        chk("drop_count_sat", {2'b00, drop_count}, 10'd255);
        chk("stats_model", dut_vec(), model_vec());
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
